// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - serial-line and byte-handshake bundle for uart_rx_os
interface uart_rx_os_if;
    logic       i_Rx_Serial;
    logic       i_Rx_Ready;
    logic       o_Rx_Valid;
    logic [7:0] o_Rx_Byte;
    logic       o_Frame_Err;
    logic       o_Overrun;
    logic       o_Parity_Err;
    logic       o_Rx_Busy;

    // Receiver side: samples the line, presents the held byte.
    modport slave (
        input  i_Rx_Serial,
        input  i_Rx_Ready,
        output o_Rx_Valid,
        output o_Rx_Byte,
        output o_Frame_Err,
        output o_Overrun,
        output o_Parity_Err,
        output o_Rx_Busy
    );

    // Line driver / byte consumer side.
    modport master (
        output i_Rx_Serial,
        output i_Rx_Ready,
        input  o_Rx_Valid,
        input  o_Rx_Byte,
        input  o_Frame_Err,
        input  o_Overrun,
        input  o_Parity_Err,
        input  o_Rx_Busy
    );
endinterface

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - majority-vote UART receiver with one-byte holding register (option macro UART_RX_PARITY_EN)
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_ODD   = 0
) (
    input  logic         i_Clock,
    input  logic         i_Reset_n,
    uart_rx_os_if.slave  rx
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] SMP_A = MID - CNT_W'(1);
    localparam logic [CNT_W-1:0] SMP_C = MID + CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t            state, state_n;
    logic [1:0]        sync;
    logic              rx_s;
    logic [CNT_W-1:0]  clk_cnt, cnt_n;
    logic [2:0]        bit_idx, bit_n;
    logic [7:0]        shreg, shreg_n;
    logic              smp0, smp0_n, smp1, smp1_n;
    logic              par_bit, par_n;
    logic              maj, decide, bit_end, par_bad;
    logic              byte_done, fe_set, pe_set;
    logic              valid_q, frame_err_q, overrun_q, parity_err_q;
    logic [7:0]        byte_q;

    assign rx_s    = sync[1];
    assign maj     = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign decide  = (clk_cnt == SMP_C);
    assign bit_end = (clk_cnt == LAST);

`ifdef UART_RX_PARITY_EN
    assign par_bad = ((^shreg) ^ par_bit) != PARITY_ODD[0];
`else
    logic unused_parity;
    assign unused_parity = PARITY_ODD[0] ^ par_bit;
    assign par_bad       = 1'b0;
`endif

    // Two-flop synchronizer; presets to the idle-high line level.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) sync <= 2'b11;
        else            sync <= {sync[0], rx.i_Rx_Serial};
    end

    // Frame state register.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= IDLE;
        else            state <= state_n;
    end

    // Next-state, bit timing, majority sampling and completion strobes.
    always_comb begin
        state_n   = state;
        cnt_n     = clk_cnt;
        bit_n     = bit_idx;
        shreg_n   = shreg;
        smp0_n    = smp0;
        smp1_n    = smp1;
        par_n     = par_bit;
        byte_done = 1'b0;
        fe_set    = 1'b0;
        pe_set    = 1'b0;

        if (state != IDLE && state != BREAK) begin
            cnt_n = bit_end ? '0 : clk_cnt + CNT_W'(1);
            if (clk_cnt == SMP_A) smp0_n = rx_s;
            if (clk_cnt == MID)   smp1_n = rx_s;
        end

        case (state)
            IDLE: begin
                cnt_n = '0;
                // The cycle that first sees the low line counts as tick 0.
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = CNT_W'(1);
                end
            end
            START: begin
                if (decide && maj) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (bit_end) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                if (decide) shreg_n = {maj, shreg[7:1]};
                if (bit_end) begin
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide)  par_n   = maj;
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                // Leave at the decision point so the next start edge is not missed.
                if (decide) begin
                    cnt_n  = '0;
                    pe_set = par_bad;
                    if (maj) begin
                        state_n   = IDLE;
                        byte_done = !par_bad;
                    end else begin
                        state_n = BREAK;
                        fe_set  = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Bit timing and shift datapath registers.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            smp0    <= 1'b1;
            smp1    <= 1'b1;
            par_bit <= 1'b0;
        end else begin
            clk_cnt <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            smp0    <= smp0_n;
            smp1    <= smp1_n;
            par_bit <= par_n;
        end
    end

    // Holding register: a same-cycle ready frees the slot for the new byte.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            valid_q      <= 1'b0;
            byte_q       <= 8'h00;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            overrun_q    <= byte_done && valid_q && !rx.i_Rx_Ready;
            frame_err_q  <= fe_set;
            parity_err_q <= pe_set;
            if (byte_done && !(valid_q && !rx.i_Rx_Ready)) begin
                byte_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && rx.i_Rx_Ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.o_Rx_Valid   = valid_q;
    assign rx.o_Rx_Byte    = byte_q;
    assign rx.o_Frame_Err  = frame_err_q;
    assign rx.o_Overrun    = overrun_q;
    assign rx.o_Parity_Err = parity_err_q;
    assign rx.o_Rx_Busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os
module tb_uart_rx_os;
    localparam int CPB    = 87;
    localparam int BIT_NS = 8700;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests  = 0;
    int   failed = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   pe_cnt = 0;
    int   fe0, ov0, pe0;
`ifdef UART_RX_PARITY_EN
    logic flip_par = 1'b0;
`endif

    always #50 clk = ~clk;

    uart_rx_os_if bus();

    uart_rx_os #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .rx        (bus)
    );

    // Count one-cycle error pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.o_Frame_Err)  fe_cnt++;
        if (bus.o_Overrun)    ov_cnt++;
        if (bus.o_Parity_Err) pe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.i_Rx_Serial = b;
        #(BIT_NS);
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_low, input logic rdy_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ flip_par);
`endif
        if (stop_low > 0) begin
            bus.i_Rx_Serial = 1'b0;
            #(stop_low * BIT_NS);
            bus.i_Rx_Serial = 1'b1;
            #(BIT_NS);
        end else begin
            bus.i_Rx_Serial = 1'b1;
            if (rdy_stop) bus.i_Rx_Ready = 1'b1;
            repeat (CPB) begin
                @(negedge clk);
                if (rdy_stop && bus.o_Rx_Valid && bus.o_Rx_Byte == d) bus.i_Rx_Ready = 1'b0;
            end
            if (rdy_stop) bus.i_Rx_Ready = 1'b0;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.o_Rx_Valid && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.o_Rx_Valid, 1);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.i_Rx_Ready = 1'b1;
        @(negedge clk);
        bus.i_Rx_Ready = 1'b0;
    endtask

    initial begin
        bus.i_Rx_Serial = 1'b1;
        bus.i_Rx_Ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.o_Rx_Valid, 0);
        check("rst_byte",  bus.o_Rx_Byte, 0);
        check("rst_fe",    bus.o_Frame_Err, 0);
        check("rst_ov",    bus.o_Overrun, 0);
        check("rst_busy",  bus.o_Rx_Busy, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Plain frame, then a one-cycle ready pulse.
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3F, 0, 1'b0);
        wait_valid("f3f_valid");
        check("f3f_byte", bus.o_Rx_Byte, 8'h3F);
        check("f3f_fe",   fe_cnt - fe0, 0);
        check("f3f_ov",   ov_cnt - ov0, 0);
        consume();
        check("f3f_cleared", bus.o_Rx_Valid, 0);

        // Short low glitch is rejected, following frame is intact.
        fe0 = fe_cnt;
        bus.i_Rx_Serial = 1'b0;
        #2000;
        bus.i_Rx_Serial = 1'b1;
        #(BIT_NS);
        check("glitch_busy",  bus.o_Rx_Busy, 0);
        check("glitch_valid", bus.o_Rx_Valid, 0);
        check("glitch_fe",    fe_cnt - fe0, 0);
        send_frame(8'hA5, 0, 1'b0);
        wait_valid("fa5_valid");
        check("fa5_byte", bus.o_Rx_Byte, 8'hA5);
        consume();

        // Stop bit held low for three bit periods: one framing error, then recovery.
        fe0 = fe_cnt;
        send_frame(8'h55, 3, 1'b0);
        repeat (20) @(negedge clk);
        check("brk_fe",    fe_cnt - fe0, 1);
        check("brk_valid", bus.o_Rx_Valid, 0);
        check("brk_busy",  bus.o_Rx_Busy, 0);
        send_frame(8'h81, 0, 1'b0);
        wait_valid("f81_valid");
        check("f81_byte", bus.o_Rx_Byte, 8'h81);
        consume();

        // Back-to-back with ready low: second byte dropped.
        ov0 = ov_cnt;
        send_frame(8'h11, 0, 1'b0);
        send_frame(8'h22, 0, 1'b0);
        check("ovr_valid", bus.o_Rx_Valid, 1);
        check("ovr_byte",  bus.o_Rx_Byte, 8'h11);
        check("ovr_count", ov_cnt - ov0, 1);
        consume();

        // Back-to-back with ready high during the second stop bit.
        ov0 = ov_cnt;
        send_frame(8'h11, 0, 1'b0);
        send_frame(8'h22, 0, 1'b1);
        check("rdy_valid", bus.o_Rx_Valid, 1);
        check("rdy_byte",  bus.o_Rx_Byte, 8'h22);
        check("rdy_ov",    ov_cnt - ov0, 0);

        // Reset in the middle of data bit 4 discards the frame and the held byte.
        fe0 = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #(BIT_NS / 2);
        rst_n = 1'b0;
        bus.i_Rx_Serial = 1'b1;
        @(negedge clk);
        check("mrst_valid", bus.o_Rx_Valid, 0);
        check("mrst_byte",  bus.o_Rx_Byte, 0);
        check("mrst_busy",  bus.o_Rx_Busy, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #(BIT_NS);
        send_frame(8'hC3, 0, 1'b0);
        wait_valid("fc3_valid");
        check("fc3_byte", bus.o_Rx_Byte, 8'hC3);
        check("fc3_fe",   fe_cnt - fe0, 0);
        consume();

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct.
        pe0 = pe_cnt;
        flip_par = 1'b0;
        send_frame(8'h07, 0, 1'b0);
        wait_valid("par_ok_valid");
        check("par_ok_byte", bus.o_Rx_Byte, 8'h07);
        check("par_ok_pe",   pe_cnt - pe0, 0);
        consume();
        pe0 = pe_cnt;
        flip_par = 1'b1;
        send_frame(8'h07, 0, 1'b0);
        repeat (20) @(negedge clk);
        check("par_bad_pe",    pe_cnt - pe0, 1);
        check("par_bad_valid", bus.o_Rx_Valid, 0);
        flip_par = 1'b0;
`else
        pe0 = 0;
        check("par_tied", pe_cnt - pe0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
